// File: rtl/nco_sincos_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_sincos_gen_pkg
// Description : Shared DSP definitions for the carrier-recovery datapath.
//               Holds the S(8,6) operand format defaults used by both the
//               NCO and the rotator, the S(8,6) unit constant, and the
//               quadrant-folding helper used by the sin/cos generator.
// Revision    : 1.0 - initial release
// ============================================================================
package nco_sincos_gen_pkg;

    // Rotator / NCO operand format S(8,6)
    localparam int            c_nb_output_def  = 8;
    localparam int            c_nbf_output_def = 6;

    // 1.0 in S(8,6)
    localparam logic [7:0]    c_s8_6_one       = 8'h40;

    // How a quarter-wave LUT read is folded into one of four quadrants:
    // mirror -> read the LUT backwards (index N-i instead of i)
    // negate -> two's-complement the looked-up magnitude
    typedef struct packed {
        logic mirror;
        logic negate;
    } fold_t;

    // Quadrants 1 and 3 run the quarter wave backwards, quadrants 2 and 3
    // are the negative half-cycle.
    function automatic fold_t fold_quadrant(input logic [1:0] quadrant);
        fold_t fold;
        fold.mirror = quadrant[0];
        fold.negate = quadrant[1];
        return fold;
    endfunction

endpackage : nco_sincos_gen_pkg
`default_nettype wire

// File: rtl/nco_sincos_gen_sin_quarter_lut.sv
`default_nettype none
// ============================================================================
// Module      : sin_quarter_lut
// Description : Combinational quarter-wave sine ROM.
//               L[k] = round(64 * sin(pi/2 * k/64)), k = 0..64 (65 entries,
//               inclusive of both end points so that folding never needs a
//               special case for the quadrant boundary).
//               The master table is tabulated for 64 steps and 6 fractional
//               bits; other NB_ADDR / NBF_OUTPUT values resample / rescale it.
// Ports       : i_addr [NB_ADDR:0]    - LUT index 0..2^NB_ADDR
//               o_data [NBF_OUTPUT:0] - unsigned magnitude, 1.0 = 2^NBF_OUTPUT
// Revision    : 1.0 - initial release
// ============================================================================
module sin_quarter_lut
    import nco_sincos_gen_pkg::*;
#(
    parameter int NB_ADDR    = 6,
    parameter int NBF_OUTPUT = c_nbf_output_def
)(
    input  logic [NB_ADDR:0]    i_addr,
    output logic [NBF_OUTPUT:0] o_data
);

    logic [6:0] w_idx64;
    logic [6:0] w_mag64;

    // Map the caller's index onto the 64-step master table.
    generate
        if (NB_ADDR == 6) begin : g_addr_native
            assign w_idx64 = i_addr;
        end else if (NB_ADDR < 6) begin : g_addr_upsample
            assign w_idx64 = 7'(i_addr) << (6 - NB_ADDR);
        end else begin : g_addr_downsample
            assign w_idx64 = 7'(i_addr >> (NB_ADDR - 6));
        end
    endgenerate

    always_comb begin
        w_mag64 = 7'd0;
        case (w_idx64)
            7'd0 : w_mag64 = 7'd0;   7'd1 : w_mag64 = 7'd2;   7'd2 : w_mag64 = 7'd3;
            7'd3 : w_mag64 = 7'd5;   7'd4 : w_mag64 = 7'd6;   7'd5 : w_mag64 = 7'd8;
            7'd6 : w_mag64 = 7'd9;   7'd7 : w_mag64 = 7'd11;  7'd8 : w_mag64 = 7'd12;
            7'd9 : w_mag64 = 7'd14;  7'd10: w_mag64 = 7'd16;  7'd11: w_mag64 = 7'd17;
            7'd12: w_mag64 = 7'd19;  7'd13: w_mag64 = 7'd20;  7'd14: w_mag64 = 7'd22;
            7'd15: w_mag64 = 7'd23;  7'd16: w_mag64 = 7'd24;  7'd17: w_mag64 = 7'd26;
            7'd18: w_mag64 = 7'd27;  7'd19: w_mag64 = 7'd29;  7'd20: w_mag64 = 7'd30;
            7'd21: w_mag64 = 7'd32;  7'd22: w_mag64 = 7'd33;  7'd23: w_mag64 = 7'd34;
            7'd24: w_mag64 = 7'd36;  7'd25: w_mag64 = 7'd37;  7'd26: w_mag64 = 7'd38;
            7'd27: w_mag64 = 7'd39;  7'd28: w_mag64 = 7'd41;  7'd29: w_mag64 = 7'd42;
            7'd30: w_mag64 = 7'd43;  7'd31: w_mag64 = 7'd44;  7'd32: w_mag64 = 7'd45;
            7'd33: w_mag64 = 7'd46;  7'd34: w_mag64 = 7'd47;  7'd35: w_mag64 = 7'd48;
            7'd36: w_mag64 = 7'd49;  7'd37: w_mag64 = 7'd50;  7'd38: w_mag64 = 7'd51;
            7'd39: w_mag64 = 7'd52;  7'd40: w_mag64 = 7'd53;  7'd41: w_mag64 = 7'd54;
            7'd42: w_mag64 = 7'd55;  7'd43: w_mag64 = 7'd56;  7'd44: w_mag64 = 7'd56;
            7'd45: w_mag64 = 7'd57;  7'd46: w_mag64 = 7'd58;  7'd47: w_mag64 = 7'd59;
            7'd48: w_mag64 = 7'd59;  7'd49: w_mag64 = 7'd60;  7'd50: w_mag64 = 7'd60;
            7'd51: w_mag64 = 7'd61;  7'd52: w_mag64 = 7'd61;  7'd53: w_mag64 = 7'd62;
            7'd54: w_mag64 = 7'd62;  7'd55: w_mag64 = 7'd62;  7'd56: w_mag64 = 7'd63;
            7'd57: w_mag64 = 7'd63;  7'd58: w_mag64 = 7'd63;  7'd59: w_mag64 = 7'd64;
            7'd60: w_mag64 = 7'd64;  7'd61: w_mag64 = 7'd64;  7'd62: w_mag64 = 7'd64;
            7'd63: w_mag64 = 7'd64;  7'd64: w_mag64 = 7'd64;
            default: w_mag64 = 7'd0;
        endcase
    end

    // Rescale the 6-fractional-bit table onto the requested output format.
    generate
        if (NBF_OUTPUT == 6) begin : g_data_native
            assign o_data = w_mag64;
        end else if (NBF_OUTPUT > 6) begin : g_data_widen
            assign o_data = (NBF_OUTPUT + 1)'(w_mag64) << (NBF_OUTPUT - 6);
        end else begin : g_data_narrow
            assign o_data = (NBF_OUTPUT + 1)'(w_mag64 >> (6 - NBF_OUTPUT));
        end
    endgenerate

endmodule : sin_quarter_lut
`default_nettype wire

// File: rtl/nco_sincos_gen.sv
`default_nettype none
// ============================================================================
// Module      : nco_sincos_gen
// Description : Numerically controlled oscillator producing the S(8,6)
//               sin/cos pair fed to the derotator. Phase accumulator ->
//               quadrant decode -> quarter-wave LUT + conditional negation.
//               Two register stages: enable in cycle t -> o_valid in t+2.
// Ports       : clock          - system clock, rising edge
//               i_reset        - synchronous active-high reset (top priority)
//               i_enable       - produce one sample, advance the phase
//               i_load         - capture i_phase_inc into increment register
//               i_phase_inc    - unsigned phase step, modulo 2^NB_PHASE
//               i_sync         - restart the accumulator at phase 0
//               i_phase_offset - static offset applied to the output phase
//               o_dataSin      - S(8,6) sin(phase)
//               o_dataCos      - S(8,6) cos(phase)
//               o_valid        - outputs hold a new sample
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sincos_gen
    import nco_sincos_gen_pkg::*;
#(
    parameter int NB_PHASE   = 16,
    parameter int NB_ADDR    = 6,
    parameter int NB_OUTPUT  = c_nb_output_def,
    parameter int NBF_OUTPUT = c_nbf_output_def
)(
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_load,
    input  logic [NB_PHASE-1:0]  i_phase_inc,
    input  logic                 i_sync,
    input  logic [NB_PHASE-1:0]  i_phase_offset,
    output logic [NB_OUTPUT-1:0] o_dataSin,
    output logic [NB_OUTPUT-1:0] o_dataCos,
    output logic                 o_valid
);

    // Phase bits that survive into the decode stage: 2 quadrant + index.
    localparam int                c_nb_idx     = NB_ADDR + 2;
    localparam int                c_nb_trunc   = NB_PHASE - c_nb_idx;
    localparam int                c_nb_mag     = NBF_OUTPUT + 1;
    // N = 2^NB_ADDR, the quarter-wave LUT end point
    localparam logic [NB_ADDR:0]  c_quarter    = {1'b1, {NB_ADDR{1'b0}}};
    localparam logic [NB_PHASE-1:0] c_phase_zero = '0;

    // ------------------------------------------------------------------
    // Stage 0: phase accumulator
    // ------------------------------------------------------------------
    logic [NB_PHASE-1:0] r_acc;
    logic [NB_PHASE-1:0] r_inc;
    logic [NB_PHASE-1:0] w_acc_base;
    logic [NB_PHASE-1:0] w_phase_sum;
    logic [c_nb_idx-1:0] r_phase1;
    logic                r_valid1;

    // i_sync substitutes phase 0 for the current accumulator value in the
    // same cycle, so the synced sample itself is already at phase 0+offset.
    assign w_acc_base  = i_sync ? c_phase_zero : r_acc;
    assign w_phase_sum = w_acc_base + i_phase_offset;

    // Phase LSBs below the LUT index are truncated, never rounded.
    generate
        if (c_nb_trunc > 0) begin : g_trunc
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^w_phase_sum[c_nb_trunc-1:0];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_inc    <= '0;
            r_phase1 <= '0;
            r_valid1 <= 1'b0;
        end else begin
            // A freshly loaded increment is seen by the next cycle's update.
            if (i_load) begin
                r_inc <= i_phase_inc;
            end
            if (i_enable) begin
                r_acc    <= w_acc_base + r_inc;
                r_phase1 <= w_phase_sum[NB_PHASE-1 -: c_nb_idx];
            end else if (i_sync) begin
                r_acc    <= '0;
            end
            r_valid1 <= i_enable;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: quadrant decode and LUT addressing
    // ------------------------------------------------------------------
    logic [1:0]          w_q_sin;
    logic [1:0]          w_q_cos;
    logic [NB_ADDR-1:0]  w_idx;
    fold_t               w_fold_sin;
    fold_t               w_fold_cos;
    logic [NB_ADDR:0]    w_addr_sin;
    logic [NB_ADDR:0]    w_addr_cos;
    logic [c_nb_mag-1:0] w_mag_sin;
    logic [c_nb_mag-1:0] w_mag_cos;

    assign w_q_sin = r_phase1[c_nb_idx-1 -: 2];
    assign w_idx   = r_phase1[NB_ADDR-1:0];
    // cos(x) = sin(x + pi/2): same fold, one quadrant ahead.
    assign w_q_cos = w_q_sin + 2'd1;

    assign w_fold_sin = fold_quadrant(w_q_sin);
    assign w_fold_cos = fold_quadrant(w_q_cos);

    assign w_addr_sin = w_fold_sin.mirror ? (c_quarter - {1'b0, w_idx}) : {1'b0, w_idx};
    assign w_addr_cos = w_fold_cos.mirror ? (c_quarter - {1'b0, w_idx}) : {1'b0, w_idx};

    sin_quarter_lut #(
        .NB_ADDR    (NB_ADDR),
        .NBF_OUTPUT (NBF_OUTPUT)
    ) u_lut_sin (
        .i_addr (w_addr_sin),
        .o_data (w_mag_sin)
    );

    sin_quarter_lut #(
        .NB_ADDR    (NB_ADDR),
        .NBF_OUTPUT (NBF_OUTPUT)
    ) u_lut_cos (
        .i_addr (w_addr_cos),
        .o_data (w_mag_cos)
    );

    // ------------------------------------------------------------------
    // Stage 2: sign application and output registers
    // ------------------------------------------------------------------
    logic [NB_OUTPUT-1:0] w_ext_sin;
    logic [NB_OUTPUT-1:0] w_ext_cos;
    logic [NB_OUTPUT-1:0] w_val_sin;
    logic [NB_OUTPUT-1:0] w_val_cos;

    assign w_ext_sin = {{(NB_OUTPUT - c_nb_mag){1'b0}}, w_mag_sin};
    assign w_ext_cos = {{(NB_OUTPUT - c_nb_mag){1'b0}}, w_mag_cos};

    // Magnitude tops out at 1.0, well inside the signed range, so plain
    // two's-complement negation cannot overflow.
    assign w_val_sin = w_fold_sin.negate ? -w_ext_sin : w_ext_sin;
    assign w_val_cos = w_fold_cos.negate ? -w_ext_cos : w_ext_cos;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_dataSin <= '0;
            o_dataCos <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= r_valid1;
            // Outputs hold their last sample across gaps.
            if (r_valid1) begin
                o_dataSin <= w_val_sin;
                o_dataCos <= w_val_cos;
            end
        end
    end

endmodule : nco_sincos_gen
`default_nettype wire

// File: tb/tb_nco_sincos_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_sincos_gen
// Description : Self-checking bench for nco_sincos_gen. A vector table with
//               hand-computed sin/cos values, hand-written reset/sync
//               sequences and a randomised run. Expected samples are queued
//               when a sample is requested and popped when o_valid is seen;
//               the reference waveform comes from real-valued sin/cos.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_sincos_gen;

    localparam int  NB_PHASE   = 16;
    localparam int  NB_ADDR    = 6;
    localparam int  NB_OUTPUT  = 8;
    localparam int  NBF_OUTPUT = 6;
    localparam real c_pi       = 3.14159265358979323846;

    logic                 clock = 1'b0;
    logic                 i_reset;
    logic                 i_enable;
    logic                 i_load;
    logic [NB_PHASE-1:0]  i_phase_inc;
    logic                 i_sync;
    logic [NB_PHASE-1:0]  i_phase_offset;
    logic [NB_OUTPUT-1:0] o_dataSin;
    logic [NB_OUTPUT-1:0] o_dataCos;
    logic                 o_valid;

    always #5 clock = ~clock;

    nco_sincos_gen #(
        .NB_PHASE   (NB_PHASE),
        .NB_ADDR    (NB_ADDR),
        .NB_OUTPUT  (NB_OUTPUT),
        .NBF_OUTPUT (NBF_OUTPUT)
    ) dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_load         (i_load),
        .i_phase_inc    (i_phase_inc),
        .i_sync         (i_sync),
        .i_phase_offset (i_phase_offset),
        .o_dataSin      (o_dataSin),
        .o_dataCos      (o_dataCos),
        .o_valid        (o_valid)
    );

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
    } exp_t;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] inc;
        logic        sy;
        logic [15:0] off;
        logic [7:0]  sin_e;
        logic [7:0]  cos_e;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    logic [15:0] m_acc;
    logic [15:0] m_inc;
    logic        m_v1;
    logic [7:0]  last_sin;
    logic [7:0]  last_cos;
    int          n_checks = 0;
    int          n_fail   = 0;

    // round(64 * sin/cos(2*pi*k/256)), k = top 8 phase bits
    function automatic logic [7:0] ref_wave(input logic [15:0] p, input bit is_cos);
        int  idx;
        real a;
        real y;
        int  r;
        idx = int'(p >> (NB_PHASE - NB_ADDR - 2));
        a   = 2.0 * c_pi * real'(idx) / 256.0;
        y   = 64.0 * (is_cos ? $cos(a) : $sin(a));
        r   = (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(-y + 0.5);
        return 8'(r);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%02h, expected 0x%02h", name, $time, act, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, update the model, then check outputs.
    task automatic cycle(input logic en, input logic ld, input logic [15:0] inc,
                         input logic sy, input logic [15:0] off,
                         input bit use_exp, input logic [7:0] es, input logic [7:0] ec);
        logic [15:0] base;
        logic [15:0] p;
        exp_t        e;
        exp_t        got;
        logic        exp_valid;
        i_enable       = en;
        i_load         = ld;
        i_phase_inc    = inc;
        i_sync         = sy;
        i_phase_offset = off;
        if (en) begin
            base = sy ? 16'h0000 : m_acc;
            p    = base + off;
            e.s  = use_exp ? es : ref_wave(p, 1'b0);
            e.c  = use_exp ? ec : ref_wave(p, 1'b1);
            sb.push_back(e);
            m_acc = base + m_inc;
        end else if (sy) begin
            m_acc = 16'h0000;
        end
        if (ld) m_inc = inc;
        exp_valid = m_v1;
        m_v1      = en;
        @(posedge clock);
        #1;
        check("valid", 8'(o_valid), 8'(exp_valid));
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow @%0t: got o_valid=1, expected no sample pending", $time);
            end else begin
                got = sb.pop_front();
                check("sin", o_dataSin, got.s);
                check("cos", o_dataCos, got.c);
                last_sin = got.s;
                last_cos = got.c;
            end
        end else begin
            check("hold_sin", o_dataSin, last_sin);
            check("hold_cos", o_dataCos, last_cos);
        end
    endtask

    // Reset with arbitrary other inputs applied; reset must win over them.
    task automatic do_reset(input logic en, input logic ld, input logic [15:0] inc);
        i_reset        = 1'b1;
        i_enable       = en;
        i_load         = ld;
        i_phase_inc    = inc;
        i_sync         = 1'b0;
        i_phase_offset = 16'h0000;
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        sb.delete();
        m_acc    = 16'h0000;
        m_inc    = 16'h0000;
        m_v1     = 1'b0;
        last_sin = 8'h00;
        last_cos = 8'h00;
        check("reset_valid", 8'(o_valid), 8'h00);
        check("reset_sin", o_dataSin, 8'h00);
        check("reset_cos", o_dataCos, 8'h00);
    endtask

    task automatic add(input logic en, input logic ld, input logic [15:0] inc, input logic sy,
                       input logic [15:0] off, input logic [7:0] s, input logic [7:0] c);
        vec_t v;
        v.en = en; v.ld = ld; v.inc = inc; v.sy = sy; v.off = off; v.sin_e = s; v.cos_e = c;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r_off;

        // inc=0, offset=0: constant sin=0, cos=1.0
        for (int k = 0; k < 3; k++) add(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h40);
        // quarter-turn steps
        add(0, 1, 16'h4000, 0, 16'h0000, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            add(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h40);
            add(1, 0, 16'h0000, 0, 16'h0000, 8'h40, 8'h00);
            add(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'hC0);
            add(1, 0, 16'h0000, 0, 16'h0000, 8'hC0, 8'h00);
        end
        // eighth-turn steps, including the wrap back to phase 0
        add(0, 1, 16'h2000, 0, 16'h0000, 8'h00, 8'h00);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h40);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'h2D, 8'h2D);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'h40, 8'h00);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'h2D, 8'hD3);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'hC0);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'hD3, 8'hD3);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'hC0, 8'h00);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'hD3, 8'h2D);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h40);
        // negative rotation with half-turn offset: acc 0 -> FFFF -> FFFE
        add(0, 1, 16'hFFFF, 1, 16'h0000, 8'h00, 8'h00);
        add(1, 0, 16'h0000, 0, 16'h8000, 8'h00, 8'hC0);
        add(1, 0, 16'h0000, 0, 16'h8000, 8'h02, 8'hC0);
        add(1, 0, 16'h0000, 0, 16'h8000, 8'h02, 8'hC0);
        // enable gaps: phase advances only on enabled cycles
        add(0, 1, 16'h4000, 1, 16'h0000, 8'h00, 8'h00);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h40);
        add(0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00);
        add(0, 0, 16'h0000, 0, 16'h0000, 8'h00, 8'h00);
        add(1, 0, 16'h0000, 0, 16'h0000, 8'h40, 8'h00);
        // sync mid-stream with offset 0x2000 (acc was 0x8000)
        add(1, 0, 16'h0000, 1, 16'h2000, 8'h2D, 8'h2D);
        add(1, 0, 16'h0000, 0, 16'h2000, 8'h2D, 8'hD3);

        i_reset        = 1'b1;
        i_enable       = 1'b0;
        i_load         = 1'b0;
        i_phase_inc    = 16'h0000;
        i_sync         = 1'b0;
        i_phase_offset = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        do_reset(1'b0, 1'b0, 16'h0000);

        foreach (vecs[k]) begin
            cycle(vecs[k].en, vecs[k].ld, vecs[k].inc, vecs[k].sy, vecs[k].off,
                  1'b1, vecs[k].sin_e, vecs[k].cos_e);
        end

        // Reset while samples are in flight, with enable/load held high.
        cycle(1, 1, 16'h1000, 0, 16'h0000, 1'b0, 8'h00, 8'h00);
        cycle(1, 0, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 8'h00);
        do_reset(1'b1, 1'b1, 16'h1234);
        for (int k = 0; k < 3; k++) cycle(0, 0, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 8'h00);
        // increment must still be 0 after reset: both samples at phase 0x1000
        cycle(1, 0, 16'h0000, 0, 16'h1000, 1'b0, 8'h00, 8'h00);
        cycle(1, 0, 16'h0000, 0, 16'h1000, 1'b0, 8'h00, 8'h00);

        // Randomised traffic against the reference model.
        r_off = 16'h0000;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) r_off = 16'($urandom);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 16'($urandom),
                  ($urandom_range(0, 15) == 0), r_off, 1'b0, 8'h00, 8'h00);
        end

        for (int k = 0; k < 3; k++) cycle(0, 0, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 8'h00);
        check("sb_drained", 8'(sb.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nco_sincos_gen
`default_nettype wire
